game_flow_ctrl: RTL and testbench
=================================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  OVER_FRAMES, 180, frames spent in OVER before automatic return to MENU.
  KEY_ENTER, 8'd40, start key.
  KEY_ESC, 8'd41, quit key.
  KEY_PAUSE, 8'd19, pause toggle key ('P').
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  Clk, in, 1, system clock; the only clock.
  Reset, in, 1, synchronous, active-low reset.
  frame_clk, in, 1, VGA frame strobe, asynchronous to Clk.
  keycode, in, 8, current USB HID keycode; 0 means no key.
  doodle_fell, in, 1, level; doodle below the screen bottom.
  score, in, 16, current game score from the scoring logic.
  state, out, 3, game state code.
  game_rst, out, 1, one-Clk pulse that re-initialises doodle, platforms and score.
  frame_tick, out, 1, one-Clk pulse per frame while in PLAY.
  run_en, out, 1, high while in PLAY.
  hi_score, out, 16, best score since reset.
  new_record, out, 1, high in OVER if the last game set hi_score.

Function
REQ-003 States and codes SHALL be: MENU=0, START=1, PLAY=2, PAUSE=3, OVER=4. The state output SHALL be the registered state.
REQ-004 A key event SHALL be defined as keycode != 0 and keycode != keycode registered on the previous Clk. A held key SHALL produce exactly one event.
REQ-005 frame_clk SHALL pass through a 2-flop synchroniser plus an edge register. A frame edge SHALL be asserted for one Clk, 3 Clk after a frame_clk rising edge.
REQ-006 MENU: a KEY_ENTER event -> START. All other inputs SHALL be ignored.
REQ-007 START SHALL last exactly one Clk, assert game_rst, clear the OVER counter, and then go to PLAY.
REQ-008 PLAY transitions SHALL be: KEY_ESC event -> MENU; otherwise doodle_fell=1 -> OVER; otherwise KEY_PAUSE event -> PAUSE. Priority SHALL be Esc > fell > pause.
REQ-009 PAUSE transitions SHALL be: KEY_PAUSE event -> PLAY; KEY_ESC event -> MENU. Frame edges SHALL be ignored in PAUSE.
REQ-010 OVER: a KEY_ENTER event -> START. On each frame edge the counter SHALL increment. The frame edge on which the counter reaches OVER_FRAMES -> MENU. If Enter and expiry occur on the same Clk, Enter SHALL win.
REQ-011 OVER counter width SHALL be $clog2(OVER_FRAMES+1). The counter SHALL saturate and never wrap.
REQ-012 frame_tick SHALL equal (frame edge AND state==PLAY). run_en SHALL equal (state==PLAY). Both SHALL be combinational from registered state.
REQ-013 On the PLAY->OVER transition Clk: if score > hi_score, then hi_score <= score and new_record <= 1; otherwise new_record <= 0. Equal score SHALL NOT count as a record.
REQ-014 new_record SHALL clear on entry to START or MENU. hi_score SHALL persist across games and SHALL change only per REQ-013 or on reset.
REQ-015 Key events and doodle_fell SHALL take effect on the next Clk edge; state latency SHALL be 1 Clk.

Reset
REQ-016 While Reset=0 at a Clk edge, the following SHALL load: state=MENU, game_rst=0, hi_score=0, new_record=0, OVER counter=0, previous-keycode register=0, synchroniser and edge flops=0.
REQ-017 Reset SHALL override every transition, including mid-PLAY, mid-OVER and during the START pulse. game_rst SHALL NOT be asserted by reset itself.
REQ-018 A key held across reset deassertion SHALL produce one event on the first Clk after reset, because the previous-keycode register is 0.

Structure
REQ-019 Shared package game_pkg SHALL hold game_state_t, the enum of REQ-003, and the KEY_* code constants. The parameters SHALL default from these constants.
REQ-020 Sub-module frame_edge_sync SHALL implement REQ-005, with inputs Clk, Reset and async_in and output rise_pulse. The key-event register and FSM SHALL live in game_flow_ctrl.

Verification
REQ-021 Reset low for 2 Clk mid-PLAY -> state=0, hi_score=0, game_rst=0 on the first Clk after release.
REQ-022 In MENU, keycode 40 held for 50 Clk -> exactly one game_rst pulse, then state 1 for one Clk, then state 2. No second START.
REQ-023 In PLAY with 3 frame_clk rising edges -> exactly 3 frame_tick pulses, each 3 Clk after its edge. After the key-19 event -> state 3, and a further frame edge gives no frame_tick. A second 19 event (after a keycode=0 gap) -> state 2.
REQ-024 In PLAY, keycode 41 event and doodle_fell=1 on the same Clk -> state=0, hi_score unchanged.
REQ-025 With score=500 and hi_score=0, doodle_fell -> state 4, hi_score=500, new_record=1. Next game score=500 -> new_record=0, hi_score=500.
REQ-026 In OVER with OVER_FRAMES=4: 4 frame edges -> state 0 on the 4th edge. Enter event coinciding with the 4th edge -> state 1 then game_rst.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the game flow controller: state encoding,
// default keycodes and timing constants.
package game_pkg;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_START = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    localparam logic [7:0] KEY_ENTER_CODE      = 8'd40;
    localparam logic [7:0] KEY_ESC_CODE        = 8'd41;
    localparam logic [7:0] KEY_PAUSE_CODE      = 8'd19;
    localparam int         OVER_FRAMES_DEFAULT = 180;

endpackage

// File: rtl/frame_edge_sync.sv
// Brings the asynchronous VGA frame strobe into the Clk domain and emits a
// registered one-Clk pulse three Clk edges after each rising edge.
module frame_edge_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;
    logic rise_q,  rise_d;

    // Next-state for the synchroniser chain and rising-edge detector.
    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise_d  = sync2_q & ~prev_q;
    end

    // Synchroniser, edge history and pulse registers with synchronous reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values and the chain shifts by exactly one stage.
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign rise_pulse = rise_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game flow: MENU/START/PLAY/PAUSE/OVER state machine, key-event
// detection, frame gating, OVER timeout and high-score tracking.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int         OVER_FRAMES = OVER_FRAMES_DEFAULT,
    parameter logic [7:0] KEY_ENTER   = KEY_ENTER_CODE,
    parameter logic [7:0] KEY_ESC     = KEY_ESC_CODE,
    parameter logic [7:0] KEY_PAUSE   = KEY_PAUSE_CODE
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic        doodle_fell,
    input  logic [15:0] score,
    output logic [2:0]  state,
    output logic        game_rst,
    output logic        frame_tick,
    output logic        run_en,
    output logic [15:0] hi_score,
    output logic        new_record
);

    localparam int               CNT_W   = $clog2(OVER_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVER_FRAMES);

    game_state_t      state_q, state_d;
    logic [7:0]       key_prev_q, key_prev_d;
    logic [CNT_W-1:0] over_cnt_q, over_cnt_d;
    logic [15:0]      hi_score_q, hi_score_d;
    logic             new_record_q, new_record_d;
    logic             game_rst_q, game_rst_d;

    logic             frame_edge;
    logic             key_ev;
    logic             enter_ev;
    logic             esc_ev;
    logic             pause_ev;
    logic [CNT_W-1:0] over_cnt_inc;

    frame_edge_sync u_frame_edge_sync (
        .Clk        (Clk),
        .Reset      (Reset),
        .async_in   (frame_clk),
        .rise_pulse (frame_edge)
    );

    // Key events: a new non-zero code; a held key fires only once.
    always_comb begin
        key_prev_d = keycode;
        key_ev     = (keycode != 8'd0) && (keycode != key_prev_q);
        enter_ev   = key_ev && (keycode == KEY_ENTER);
        esc_ev     = key_ev && (keycode == KEY_ESC);
        pause_ev   = key_ev && (keycode == KEY_PAUSE);
    end

    // Next state, OVER counter, high score and record flag.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the case leaves it unassigned and infers a latch.
        state_d      = state_q;
        over_cnt_d   = over_cnt_q;
        hi_score_d   = hi_score_q;
        new_record_d = new_record_q;
        over_cnt_inc = (over_cnt_q == CNT_MAX) ? over_cnt_q : over_cnt_q + CNT_W'(1);

        case (state_q)
            ST_MENU: begin
                if (enter_ev) state_d = ST_START;
            end
            ST_START: begin
                over_cnt_d = '0;
                state_d    = ST_PLAY;
            end
            ST_PLAY: begin
                if (esc_ev)           state_d = ST_MENU;
                else if (doodle_fell) state_d = ST_OVER;
                else if (pause_ev)    state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_ev)      state_d = ST_PLAY;
                else if (esc_ev)   state_d = ST_MENU;
            end
            ST_OVER: begin
                if (frame_edge) over_cnt_d = over_cnt_inc;
                // Enter takes precedence over the timeout landing on the same Clk.
                if (enter_ev)                                        state_d = ST_START;
                else if (frame_edge && (over_cnt_inc == CNT_MAX))    state_d = ST_MENU;
            end
            default: state_d = ST_MENU;
        endcase

        // Score is judged only on the Clk the game ends by falling.
        if ((state_q == ST_PLAY) && (state_d == ST_OVER)) begin
            if (score > hi_score_q) begin
                hi_score_d   = score;
                new_record_d = 1'b1;
            end else begin
                new_record_d = 1'b0;
            end
        end

        if ((state_d == ST_START) || (state_d == ST_MENU)) new_record_d = 1'b0;

        // The reset pulse is aligned with the START state itself.
        game_rst_d = (state_d == ST_START);
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= ST_MENU;
            key_prev_q   <= 8'd0;
            over_cnt_q   <= '0;
            hi_score_q   <= 16'd0;
            new_record_q <= 1'b0;
            game_rst_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_prev_q   <= key_prev_d;
            over_cnt_q   <= over_cnt_d;
            hi_score_q   <= hi_score_d;
            new_record_q <= new_record_d;
            game_rst_q   <= game_rst_d;
        end
    end

    assign state      = state_q;
    assign game_rst   = game_rst_q;
    assign run_en     = (state_q == ST_PLAY);
    assign frame_tick = frame_edge && (state_q == ST_PLAY);
    assign hi_score   = hi_score_q;
    assign new_record = new_record_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a due-cycle scoreboard of expected
// output values.
module tb_game_flow_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic [7:0]  keycode = 8'd0;
    logic        doodle_fell = 1'b0;
    logic [15:0] score = 16'd0;
    logic [2:0]  state;
    logic        game_rst;
    logic        frame_tick;
    logic        run_en;
    logic [15:0] hi_score;
    logic        new_record;

    game_flow_ctrl #(.OVER_FRAMES(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .doodle_fell (doodle_fell),
        .score       (score),
        .state       (state),
        .game_rst    (game_rst),
        .frame_tick  (frame_tick),
        .run_en      (run_en),
        .hi_score    (hi_score),
        .new_record  (new_record)
    );

    always #5 Clk = ~Clk;

    typedef enum int {F_STATE, F_GRST, F_TICK, F_RUN, F_HI, F_NR} field_t;
    typedef struct {
        string       tag;
        int          due;
        field_t      field;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   grst_cnt = 0;
    int   tick_cnt = 0;

    function automatic logic [15:0] observe(field_t f);
        case (f)
            F_STATE: return {13'd0, state};
            F_GRST:  return {15'd0, game_rst};
            F_TICK:  return {15'd0, frame_tick};
            F_RUN:   return {15'd0, run_en};
            F_HI:    return hi_score;
            F_NR:    return {15'd0, new_record};
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Queue an expectation to be compared dly Clk edges from now.
    task automatic expect_at(string tag, int dly, field_t f, logic [15:0] v);
        exp_t e;
        e.tag   = tag;
        e.due   = cyc + dly;
        e.field = f;
        e.val   = v;
        sb.push_back(e);
    endtask

    // Advance n Clk edges, sampling 1 time unit after each edge.
    task automatic step(int n);
        int i;
        repeat (n) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (game_rst)   grst_cnt++;
            if (frame_tick) tick_cnt++;
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].due == cyc) begin
                    check(sb[i].tag, observe(sb[i].field), sb[i].val);
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
    endtask

    // One frame_clk high period lasting one Clk, then idle for the rest.
    task automatic frame_pulse(int idle);
        frame_clk = 1'b1;
        step(1);
        frame_clk = 1'b0;
        step(idle);
    endtask

    initial begin
        // Reset values
        Reset = 1'b0;
        step(1);
        expect_at("rst_state", 1, F_STATE, 16'd0);
        expect_at("rst_grst",  1, F_GRST,  16'd0);
        expect_at("rst_hi",    1, F_HI,    16'd0);
        expect_at("rst_nr",    1, F_NR,    16'd0);
        expect_at("rst_run",   1, F_RUN,   16'd0);
        expect_at("rst_tick",  1, F_TICK,  16'd0);
        step(1);
        Reset = 1'b1;
        step(1);

        // MENU ignores everything except Enter
        keycode = 8'd41;
        doodle_fell = 1'b1;
        expect_at("menu_ignore", 1, F_STATE, 16'd0);
        step(1);
        keycode = 8'd0;
        doodle_fell = 1'b0;
        step(1);

        // Held Enter: one START, one game_rst pulse
        grst_cnt = 0;
        keycode = 8'd40;
        expect_at("enter_start",  1, F_STATE, 16'd1);
        expect_at("enter_grst",   1, F_GRST,  16'd1);
        expect_at("start_play",   2, F_STATE, 16'd2);
        expect_at("start_grst0",  2, F_GRST,  16'd0);
        expect_at("play_run",     2, F_RUN,   16'd1);
        expect_at("hold_play",   50, F_STATE, 16'd2);
        step(50);
        check("hold_one_grst", 16'(grst_cnt), 16'd1);
        keycode = 8'd0;
        step(1);

        // Frame ticks in PLAY, each 3 Clk after its edge
        tick_cnt = 0;
        repeat (3) begin
            expect_at("tick_pre",  2, F_TICK, 16'd0);
            expect_at("tick_on",   3, F_TICK, 16'd1);
            expect_at("tick_post", 4, F_TICK, 16'd0);
            frame_pulse(5);
        end
        check("tick_count", 16'(tick_cnt), 16'd3);

        // Pause, frame ignored, resume
        keycode = 8'd19;
        expect_at("pause_state", 1, F_STATE, 16'd3);
        expect_at("pause_run",   1, F_RUN,   16'd0);
        step(1);
        keycode = 8'd0;
        step(1);
        expect_at("pause_no_tick", 3, F_TICK,  16'd0);
        expect_at("pause_hold",    4, F_STATE, 16'd3);
        frame_pulse(5);
        keycode = 8'd19;
        expect_at("resume_state", 1, F_STATE, 16'd2);
        step(1);
        keycode = 8'd0;
        step(1);

        // Esc beats fell; no score update
        score = 16'd500;
        keycode = 8'd41;
        doodle_fell = 1'b1;
        expect_at("esc_fell_state", 1, F_STATE, 16'd0);
        expect_at("esc_fell_hi",    1, F_HI,    16'd0);
        expect_at("esc_fell_nr",    1, F_NR,    16'd0);
        step(1);
        keycode = 8'd0;
        doodle_fell = 1'b0;
        step(1);

        // New record on fall
        keycode = 8'd40;
        expect_at("g2_start", 1, F_STATE, 16'd1);
        expect_at("g2_play",  2, F_STATE, 16'd2);
        step(2);
        keycode = 8'd0;
        doodle_fell = 1'b1;
        expect_at("rec_state", 1, F_STATE, 16'd4);
        expect_at("rec_hi",    1, F_HI,    16'd500);
        expect_at("rec_nr",    1, F_NR,    16'd1);
        expect_at("over_run",  1, F_RUN,   16'd0);
        step(1);
        doodle_fell = 1'b0;
        step(1);

        // Enter from OVER restarts; equal score is not a record
        keycode = 8'd40;
        expect_at("over_enter_state", 1, F_STATE, 16'd1);
        expect_at("over_enter_grst",  1, F_GRST,  16'd1);
        expect_at("over_enter_nr",    1, F_NR,    16'd0);
        expect_at("g3_play",          2, F_STATE, 16'd2);
        step(2);
        keycode = 8'd0;
        doodle_fell = 1'b1;
        expect_at("equal_state", 1, F_STATE, 16'd4);
        expect_at("equal_hi",    1, F_HI,    16'd500);
        expect_at("equal_nr",    1, F_NR,    16'd0);
        step(1);
        doodle_fell = 1'b0;
        step(1);

        // OVER timeout after 4 frame edges
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) begin
                expect_at("over_wait", 4, F_STATE, 16'd4);
            end else begin
                expect_at("over_last_pre", 3, F_STATE, 16'd4);
                expect_at("over_expire",   4, F_STATE, 16'd0);
            end
            frame_pulse(5);
        end

        // Higher score sets a new record
        keycode = 8'd40;
        expect_at("g4_play", 2, F_STATE, 16'd2);
        step(2);
        keycode = 8'd0;
        score = 16'd700;
        doodle_fell = 1'b1;
        expect_at("rec2_state", 1, F_STATE, 16'd4);
        expect_at("rec2_hi",    1, F_HI,    16'd700);
        expect_at("rec2_nr",    1, F_NR,    16'd1);
        step(1);
        doodle_fell = 1'b0;
        step(1);

        // Enter coinciding with the expiring frame edge wins
        repeat (3) begin
            expect_at("over_wait2", 4, F_STATE, 16'd4);
            frame_pulse(5);
        end
        frame_pulse(2);
        keycode = 8'd40;
        expect_at("tie_state", 1, F_STATE, 16'd1);
        expect_at("tie_grst",  1, F_GRST,  16'd1);
        expect_at("tie_play",  2, F_STATE, 16'd2);
        expect_at("tie_hi",    2, F_HI,    16'd700);
        step(2);
        keycode = 8'd0;

        // Lower score keeps the best
        score = 16'd300;
        doodle_fell = 1'b1;
        expect_at("low_state", 1, F_STATE, 16'd4);
        expect_at("low_hi",    1, F_HI,    16'd700);
        expect_at("low_nr",    1, F_NR,    16'd0);
        step(1);
        doodle_fell = 1'b0;
        keycode = 8'd40;
        expect_at("g6_play", 2, F_STATE, 16'd2);
        step(2);
        keycode = 8'd0;
        step(1);

        // Reset mid-PLAY for 2 Clk
        Reset = 1'b0;
        expect_at("midrst_state", 1, F_STATE, 16'd0);
        expect_at("midrst_grst",  1, F_GRST,  16'd0);
        expect_at("midrst_hi",    1, F_HI,    16'd0);
        step(2);
        Reset = 1'b1;
        expect_at("postrst_state", 1, F_STATE, 16'd0);
        expect_at("postrst_hi",    1, F_HI,    16'd0);
        expect_at("postrst_grst",  1, F_GRST,  16'd0);
        step(2);

        // Reset during START, key held across release
        keycode = 8'd40;
        expect_at("pre_start", 1, F_STATE, 16'd1);
        step(1);
        Reset = 1'b0;
        expect_at("start_rst_state", 1, F_STATE, 16'd0);
        expect_at("start_rst_grst",  1, F_GRST,  16'd0);
        step(1);
        Reset = 1'b1;
        expect_at("held_key_state", 1, F_STATE, 16'd1);
        expect_at("held_key_grst",  1, F_GRST,  16'd1);
        expect_at("held_key_play",  2, F_STATE, 16'd2);
        step(2);
        keycode = 8'd0;
        step(3);

        check("sb_drained", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
